// File: rtl/main_register_pkg.sv
// Shared sizing constants and index type for the main register file.
package main_register_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/main_register_reg_cell.sv
// One storage word of the register file: synchronous clear, load on enable, otherwise hold.
module reg_cell
    import main_register_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/main_register.sv
// Eight-entry register file supporting IN (external load) and MOVE (register copy);
// the register selected by dest is always shown on out.
module main_register
    import main_register_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  reg_idx_t         source,
    input  reg_idx_t         dest,
    input  logic             move,
    input  logic             in,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] write_en;
    logic [WIDTH-1:0] write_data;

    // IN takes priority over MOVE; a MOVE reads the value held before the edge.
    always_comb begin
        write_data = in ? data : regs[source];
    end

    always_comb begin
        write_en = '0;
        if (in || move) begin
            write_en[dest] = 1'b1;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_cells
        reg_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (write_en[i]),
            .d    (write_data),
            .q    (regs[i])
        );
    end

    always_comb begin
        out = regs[dest];
    end

endmodule

// File: tb/tb_main_register.sv
// Randomised and directed bench for main_register against an array-based model of the register file.
module tb_main_register;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  source = '0;
    logic [2:0]  dest = '0;
    logic        move = 1'b0;
    logic        in = 1'b0;
    logic [15:0] data = '0;
    logic [15:0] out;

    logic [15:0] model [8];
    int compared = 0;
    int mismatched = 0;

    main_register dut (
        .clk    (clk),
        .rst    (rst),
        .source (source),
        .dest   (dest),
        .move   (move),
        .in     (in),
        .data   (data),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Update the model from the current controls, then take one clock edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else if (in) begin
            model[dest] = data;
        end else if (move) begin
            model[dest] = model[source];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in = 1'b0; move = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 8; d++) begin
            dest = 3'(d);
            #1;
            compared++;
            if (out !== 16'h0000) begin
                mismatched++;
                $display("[TB] FAIL reset_sweep dest=%0d got=%h exp=0000", d, out);
            end
        end
    endtask

    task automatic test_in();
        dest = 3'd0; data = 16'h0002; in = 1'b1; move = 1'b0;
        tick();
        in = 1'b0;
        compared++;
        if (out !== 16'h0002) begin
            mismatched++;
            $display("[TB] FAIL in_load got=%h exp=0002", out);
        end
    endtask

    task automatic test_move();
        source = 3'd0; dest = 3'd1; move = 1'b1; in = 1'b0;
        tick();
        move = 1'b0;
        compared++;
        if (out !== 16'h0002) begin
            mismatched++;
            $display("[TB] FAIL move_dest got=%h exp=0002", out);
        end
        dest = 3'd0;
        #1;
        compared++;
        if (out !== 16'h0002) begin
            mismatched++;
            $display("[TB] FAIL move_source_kept got=%h exp=0002", out);
        end
    endtask

    task automatic test_move_from_reset();
        dest = 3'd0; data = 16'h0001; in = 1'b1; move = 1'b0;
        tick();
        in = 1'b0;
        compared++;
        if (out !== 16'h0001) begin
            mismatched++;
            $display("[TB] FAIL reload_r0 got=%h exp=0001", out);
        end
        source = 3'd4; dest = 3'd0; move = 1'b1;
        tick();
        move = 1'b0;
        compared++;
        if (out !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL move_reset_value got=%h exp=0000", out);
        end
    endtask

    task automatic test_priority();
        dest = 3'd3; source = 3'd1; data = 16'hBEEF; in = 1'b1; move = 1'b1;
        tick();
        in = 1'b0; move = 1'b0;
        compared++;
        if (out !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL in_over_move got=%h exp=beef", out);
        end
        dest = 3'd1;
        #1;
        compared++;
        if (out !== 16'h0002) begin
            mismatched++;
            $display("[TB] FAIL source_untouched got=%h exp=0002", out);
        end
    endtask

    task automatic test_reset_priority();
        dest = 3'd5; data = 16'hFFFF; in = 1'b1;
        tick();
        compared++;
        if (out !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL load_r5 got=%h exp=ffff", out);
        end
        rst = 1'b1; data = 16'h1234;
        tick();
        rst = 1'b0; in = 1'b0;
        compared++;
        if (out !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_over_in got=%h exp=0000", out);
        end
        dest = 3'd2; data = 16'hA5A5; in = 1'b1;
        tick();
        dest = 3'd6; data = 16'h5A5A;
        tick();
        in = 1'b0; move = 1'b0; data = 16'hDEAD;
        for (int k = 0; k < 3; k++) tick();
        for (int d = 0; d < 8; d++) begin
            dest = 3'(d);
            #1;
            compared++;
            if (out !== ((d == 2) ? 16'hA5A5 : (d == 6) ? 16'h5A5A : 16'h0000)) begin
                mismatched++;
                $display("[TB] FAIL idle_hold dest=%0d got=%h", d, out);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 31) == 0);
            in     = $urandom_range(0, 2) == 0;
            move   = $urandom_range(0, 1) == 1;
            source = 3'($urandom);
            dest   = 3'($urandom);
            data   = 16'($urandom);
            tick();
            rst = 1'b0; in = 1'b0; move = 1'b0;
            dest = 3'($urandom);
            #1;
            compared++;
            if (out !== model[dest]) begin
                mismatched++;
                $display("[TB] FAIL random n=%0d dest=%0d got=%h exp=%h", n, dest, out, model[dest]);
            end
        end
        for (int d = 0; d < 8; d++) begin
            dest = 3'(d);
            #1;
            compared++;
            if (out !== model[d]) begin
                mismatched++;
                $display("[TB] FAIL final_sweep dest=%0d got=%h exp=%h", d, out, model[d]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        @(negedge clk);
        test_reset();
        test_in();
        test_move();
        test_move_from_reset();
        test_priority();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
